// File: rtl/npu_mac_pkg.sv
// Shared widths and the buffered-result payload used by the MAC result drain.
package npu_mac_pkg;

    localparam int unsigned DEF_MAX_GROUPS = 8;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    function automatic int unsigned acc_width(input int unsigned data_width);
        return 4 * data_width;
    endfunction

    function automatic int unsigned ng_width(input int unsigned max_groups);
        return $clog2(max_groups + 1);
    endfunction

    function automatic int unsigned grp_width(input int unsigned max_groups);
        return (max_groups > 1) ? $clog2(max_groups) : 1;
    endfunction

    localparam int unsigned DEF_ACC_WIDTH = acc_width(DEF_DATA_WIDTH);
    localparam int unsigned DEF_NG_W      = ng_width(DEF_MAX_GROUPS);
    localparam int unsigned DEF_VEC_W     = DEF_MAX_GROUPS * DEF_ACC_WIDTH;

    // One returned MAC result together with the group count recorded at issue.
    typedef struct packed {
        logic [DEF_NG_W-1:0]  ng;
        logic [DEF_VEC_W-1:0] vec;
    } result_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; same-cycle push and pop are legal, including when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   count_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty_c    = (count == '0);
    assign full_c     = (count == CNT_W'(DEPTH));
    assign count_c    = count;
    assign pop_data_c = mem[rd_ptr];
    assign do_pop     = pop && !empty_c;
    assign do_push    = push && (!full_c || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mac_result_drain.sv
// Buffers MAC result vectors with their issue-time group counts and drains them
// as one accumulator per beat, throttling issue so the buffer cannot overrun.
module mac_result_drain
    import npu_mac_pkg::*;
#(
    parameter int unsigned MAX_GROUPS = DEF_MAX_GROUPS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH),
    parameter int unsigned DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid,
    output logic                                 issue_ready,
    input  logic [ng_width(MAX_GROUPS)-1:0]      issue_num_groups,
    input  logic                                 mac_valid,
    input  logic [MAX_GROUPS*ACC_WIDTH-1:0]      mac_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_WIDTH-1:0]                 out_data,
    output logic [grp_width(MAX_GROUPS)-1:0]     out_group,
    output logic                                 out_last,
    output logic                                 err_overflow,
    output logic                                 err_orphan
);

    localparam int unsigned NG_W  = ng_width(MAX_GROUPS);
    localparam int unsigned GRP_W = grp_width(MAX_GROUPS);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [GRP_W-1:0] grp;
    logic [GRP_W-1:0] grp_next;
    logic [CNT_W-1:0] outstanding;

    logic             issue_accept;
    logic [NG_W-1:0]  ng_clamped;
    logic             tag_push;
    logic             tag_pop;
    logic [NG_W-1:0]  tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic [CNT_W-1:0] tag_count_unused;

    result_entry_t    res_in;
    result_entry_t    res_head;
    logic             res_push;
    logic             res_pop;
    logic             res_full;
    logic             res_empty;
    logic [CNT_W-1:0] res_count;

    logic             zero_arrival;
    logic             beat_last;
    logic             last_hs;

    assign issue_ready  = (outstanding < CNT_W'(DEPTH));
    assign issue_accept = issue_valid && issue_ready;
    assign ng_clamped   = (issue_num_groups > NG_W'(MAX_GROUPS)) ? NG_W'(MAX_GROUPS)
                                                                  : issue_num_groups;
    assign tag_push     = issue_accept && !tag_full;

    // The tag head is registered, so a tag issued this cycle cannot pair with this result.
    assign tag_pop      = mac_valid && !tag_empty;
    assign zero_arrival = tag_pop && (tag_head == '0);
    assign res_push     = tag_pop && (tag_head != '0) && !res_full;
    assign res_in.ng    = tag_head;
    assign res_in.vec   = mac_out;

    sync_fifo #(
        .WIDTH (NG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tag_push),
        .push_data  (ng_clamped),
        .pop        (tag_pop),
        .pop_data_c (tag_head),
        .full_c     (tag_full),
        .empty_c    (tag_empty),
        .count_c    (tag_count_unused)
    );

    sync_fifo #(
        .WIDTH ($bits(result_entry_t)),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (res_push),
        .push_data  (res_in),
        .pop        (res_pop),
        .pop_data_c (res_head),
        .full_c     (res_full),
        .empty_c    (res_empty),
        .count_c    (res_count)
    );

    assign out_valid = (state == ST_STREAM);
    assign beat_last = (NG_W'(grp) == (res_head.ng - NG_W'(1)));
    assign out_last  = out_valid && beat_last;
    assign out_group = out_valid ? grp : '0;
    assign out_data  = out_valid ? res_head.vec[grp*ACC_WIDTH +: ACC_WIDTH] : '0;
    assign last_hs   = out_valid && out_ready && beat_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grp   <= '0;
        end else begin
            state <= state_next;
            grp   <= grp_next;
        end
    end

    // Next head is only considered already buffered if it sits behind the current one.
    always_comb begin
        state_next = state;
        grp_next   = grp;
        res_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!res_empty) begin
                    state_next = ST_STREAM;
                    grp_next   = '0;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (beat_last) begin
                        res_pop    = 1'b1;
                        grp_next   = '0;
                        state_next = (res_count > CNT_W'(1)) ? ST_STREAM : ST_IDLE;
                    end else begin
                        grp_next = grp + GRP_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                grp_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding  <= '0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            outstanding  <= outstanding + CNT_W'(issue_accept) - CNT_W'(last_hs)
                            - CNT_W'(zero_arrival);
            err_overflow <= err_overflow || (issue_valid && !issue_ready);
            err_orphan   <= err_orphan || (mac_valid && tag_empty);
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Randomised and directed bench for mac_result_drain against a queue-based model.
module tb_mac_result_drain;

    localparam int unsigned MG    = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned NGW   = 4;
    localparam int unsigned GW    = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned VW    = MG * AW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           issue_valid = 1'b0;
    logic           issue_ready;
    logic [NGW-1:0] issue_num_groups = '0;
    logic           mac_valid = 1'b0;
    logic [VW-1:0]  mac_out = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [AW-1:0]  out_data;
    logic [GW-1:0]  out_group;
    logic           out_last;
    logic           err_overflow;
    logic           err_orphan;

    always #5 clk = ~clk;

    mac_result_drain dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_num_groups (issue_num_groups),
        .mac_valid        (mac_valid),
        .mac_out          (mac_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_group        (out_group),
        .out_last         (out_last),
        .err_overflow     (err_overflow),
        .err_orphan       (err_orphan)
    );

    typedef struct {
        logic [AW-1:0] data;
        int            grp;
        bit            last;
        int            cyc;
    } beat_t;

    beat_t expq[$];
    beat_t logq[$];
    int    tagq[$];
    int    m_out;
    bit    m_ovf;
    bit    m_orph;
    int    cyc;
    int    rnd_beats;
    bit    ir_hist[int];
    int    n_checks;
    int    n_pass;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [VW-1:0] mkvec(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] c);
        logic [VW-1:0] v;
        v = '0;
        v[0 +: AW]    = a;
        v[AW +: AW]   = b;
        v[2*AW +: AW] = c;
        return v;
    endfunction

    // Checks outputs against the model, then advances the model across the coming edge.
    task automatic monitor();
        beat_t b;
        bit    acc;
        int    ng;
        forever begin
            @(negedge clk);
            cyc++;
            ir_hist[cyc] = issue_ready;
            chk("issue_ready", longint'(issue_ready), longint'(m_out < int'(DEPTH)));
            chk("err_overflow", longint'(err_overflow), longint'(m_ovf));
            chk("err_orphan", longint'(err_orphan), longint'(m_orph));
            if (out_valid) begin
                chk("beat_pending", longint'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    chk("out_data", longint'(out_data), longint'(expq[0].data));
                    chk("out_group", longint'(out_group), longint'(expq[0].grp));
                    chk("out_last", longint'(out_last), longint'(expq[0].last));
                end
            end else begin
                chk("idle_zero", longint'({out_data, out_group, out_last}), 0);
            end
            if (rst) begin
                expq.delete();
                tagq.delete();
                m_out  = 0;
                m_ovf  = 1'b0;
                m_orph = 1'b0;
            end else begin
                acc = (m_out < int'(DEPTH));
                if (out_valid && out_ready) begin
                    b.data = out_data;
                    b.grp  = int'(out_group);
                    b.last = out_last;
                    b.cyc  = cyc;
                    logq.push_back(b);
                    if (expq.size() > 0) begin
                        b = expq.pop_front();
                        if (b.last) m_out--;
                    end
                end
                if (mac_valid) begin
                    if (tagq.size() > 0) begin
                        ng = tagq.pop_front();
                        if (ng == 0) m_out--;
                        for (int g = 0; g < ng; g++) begin
                            b.data = mac_out[g*AW +: AW];
                            b.grp  = g;
                            b.last = (g == ng - 1);
                            b.cyc  = 0;
                            expq.push_back(b);
                            rnd_beats++;
                        end
                    end else begin
                        m_orph = 1'b1;
                    end
                end
                if (issue_valid) begin
                    if (acc) begin
                        tagq.push_back((int'(issue_num_groups) > int'(MG)) ? int'(MG)
                                                                          : int'(issue_num_groups));
                        m_out++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input int ng);
        issue_valid      = 1'b1;
        issue_num_groups = NGW'(ng);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_mac(input logic [VW-1:0] v);
        mac_valid = 1'b1;
        mac_out   = v;
        tick();
        mac_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", longint'(expq.size()) + longint'(out_valid), 0);
        tick();
        tick();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk(name, longint'(out_valid), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        logq.delete();
    endtask

    task automatic check_single(input string tag);
        logic [AW-1:0] e [3];
        e[0] = 32'd100;
        e[1] = 32'hFFFF_FFFB;
        e[2] = 32'd2147483647;
        chk({tag, "_nbeats"}, logq.size(), 3);
        if (logq.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_data"}, longint'(logq[i].data), longint'(e[i]));
                chk({tag, "_group"}, logq[i].grp, i);
                chk({tag, "_last"}, longint'(logq[i].last), longint'(i == 2));
            end
        end
    endtask

    initial begin
        logic [VW-1:0] v;
        int            mc;
        int            lc;
        fork
            monitor();
        join_none

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_issue_ready", longint'(issue_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);

        // Single op: latency and back-to-back beats
        logq.delete();
        do_issue(3);
        mc = cyc + 1;
        do_mac(mkvec(32'd100, 32'hFFFF_FFFB, 32'd2147483647));
        wait_idle(50);
        check_single("single");
        if (logq.size() == 3)
            for (int i = 0; i < 3; i++) chk("single_cycle", logq[i].cyc, mc + 2 + i);
        chk("single_outstanding", m_out, 0);
        chk("single_ready", longint'(issue_ready), 1);

        // Backpressure: beat 0 held for four stalled cycles
        do_reset();
        out_ready = 1'b0;
        do_issue(3);
        do_mac(mkvec(32'd100, 32'hFFFF_FFFB, 32'd2147483647));
        wait_valid("bp_valid_timeout", 20);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", longint'(out_valid), 1);
            chk("bp_hold_data", longint'(out_data), 100);
            chk("bp_hold_group", longint'(out_group), 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(50);
        check_single("bp");

        // Full: four outstanding, fifth issue rejected
        do_reset();
        issue_valid      = 1'b1;
        issue_num_groups = NGW'(2);
        repeat (4) tick();
        @(negedge clk);
        chk("full_ready", longint'(issue_ready), 0);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("full_overflow", longint'(err_overflow), 1);
        tick();
        for (int i = 0; i < 4; i++) do_mac(mkvec(AW'(i*10+1), AW'(i*10+2), 32'd0));
        do_mac(mkvec(32'd5, 32'd5, 32'd5));
        wait_idle(100);
        chk("full_nbeats", logq.size(), 8);
        chk("full_orphan", longint'(err_orphan), 1);
        if (logq.size() >= 2) begin
            lc = logq[1].cyc;
            chk("full_ready_before_last", longint'(ir_hist[lc]), 0);
            chk("full_ready_after_last", longint'(ir_hist[lc+1]), 1);
        end

        // Back-to-back results with no bubble
        do_reset();
        out_ready = 1'b0;
        do_issue(2);
        do_issue(1);
        do_mac(mkvec(32'd7, 32'd8, 32'd0));
        do_mac(mkvec(32'd9, 32'd0, 32'd0));
        tick();
        tick();
        out_ready = 1'b1;
        wait_idle(50);
        chk("b2b_nbeats", logq.size(), 3);
        if (logq.size() == 3) begin
            chk("b2b_g0", logq[0].grp, 0);
            chk("b2b_g1", logq[1].grp, 1);
            chk("b2b_g2", logq[2].grp, 0);
            chk("b2b_last0", longint'(logq[0].last), 0);
            chk("b2b_last1", longint'(logq[1].last), 1);
            chk("b2b_last2", longint'(logq[2].last), 1);
            chk("b2b_data2", longint'(logq[2].data), 9);
            chk("b2b_gap1", logq[1].cyc - logq[0].cyc, 1);
            chk("b2b_gap2", logq[2].cyc - logq[1].cyc, 1);
        end

        // Corners: zero groups, clamp, orphan
        do_reset();
        do_issue(0);
        do_mac(mkvec(32'd1, 32'd2, 32'd3));
        wait_idle(20);
        chk("zero_nbeats", logq.size(), 0);
        chk("zero_ready", longint'(issue_ready), 1);
        chk("zero_outstanding", m_out, 0);
        do_issue(12);
        for (int g = 0; g < int'(MG); g++) v[g*AW +: AW] = AW'(1000 + g);
        do_mac(v);
        wait_idle(50);
        chk("clamp_nbeats", logq.size(), 8);
        if (logq.size() == 8) begin
            for (int g = 0; g < 8; g++) begin
                chk("clamp_data", longint'(logq[g].data), 1000 + g);
                chk("clamp_last", longint'(logq[g].last), longint'(g == 7));
            end
        end
        chk("orphan_before", longint'(err_orphan), 0);
        do_mac(mkvec(32'd5, 32'd5, 32'd5));
        wait_idle(20);
        chk("orphan_flag", longint'(err_orphan), 1);
        chk("orphan_nbeats", logq.size(), 8);

        // Reset mid-stream
        do_reset();
        do_mac(mkvec(32'd1, 32'd1, 32'd1));
        do_issue(3);
        do_mac(mkvec(32'd100, 32'hFFFF_FFFB, 32'd2147483647));
        wait_valid("mid_valid_timeout", 20);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", longint'(out_valid), 0);
        chk("mid_ready", longint'(issue_ready), 1);
        chk("mid_errs", longint'({err_overflow, err_orphan}), 0);
        tick();
        logq.delete();
        do_issue(3);
        do_mac(mkvec(32'd100, 32'hFFFF_FFFB, 32'd2147483647));
        wait_idle(50);
        check_single("mid_after");

        // Random traffic
        do_reset();
        rnd_beats = 0;
        for (int c = 0; c < 3000; c++) begin
            issue_valid      = ($urandom_range(0, 2) == 0);
            issue_num_groups = NGW'($urandom_range(0, 10));
            mac_valid        = (tagq.size() > 0 && $urandom_range(0, 2) == 0) ||
                               ($urandom_range(0, 199) == 0);
            for (int w = 0; w < int'(MG); w++) mac_out[w*AW +: AW] = $urandom;
            out_ready        = ($urandom_range(0, 3) != 0);
            tick();
        end
        issue_valid = 1'b0;
        mac_valid   = 1'b0;
        out_ready   = 1'b1;
        for (int n = 0; n < 50 && tagq.size() > 0; n++) begin
            for (int w = 0; w < int'(MG); w++) v[w*AW +: AW] = $urandom;
            do_mac(v);
        end
        wait_idle(500);
        chk("rnd_ready_end", longint'(issue_ready), 1);
        chk("rnd_beats", logq.size(), rnd_beats);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
